// File: rtl/rmt_recovery_walker.sv
// rmt_recovery_walker: after a recovery start pulse, walks the flushed
// active-list range youngest -> oldest, WALK_WIDTH entries per cycle, restoring
// the rename map table with each entry's previous physical register and
// returning its speculatively allocated physical register to the free list.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   toRecoveryPhase          one-cycle walk start pulse
//   flushRangeHeadPtr/TailPtr flushed range [head, tail)
//   alReadPtr[]              active-list read addresses, lane 0 youngest
//   alRead*[]                combinational active-list read data
//   rmtWrite*[]              RMT restore ports
//   freeListPush*[]          free-list return ports
//   busy / done              walk in progress / final walk cycle
//   protocolError            sticky: start pulse seen while walking
module rmt_recovery_walker #(
   parameter  int unsigned AL_ENTRY_NUM = 64,
   parameter  int unsigned WALK_WIDTH   = 2,
   parameter  int unsigned LREG_NUM     = 32,
   parameter  int unsigned PREG_NUM     = 64,
   localparam int unsigned AL_IW        = $clog2(AL_ENTRY_NUM),
   localparam int unsigned LW           = $clog2(LREG_NUM),
   localparam int unsigned PW           = $clog2(PREG_NUM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             toRecoveryPhase,
   input  logic [AL_IW-1:0] flushRangeHeadPtr,
   input  logic [AL_IW-1:0] flushRangeTailPtr,
   output logic [AL_IW-1:0] alReadPtr        [WALK_WIDTH],
   input  logic             alReadWriteReg   [WALK_WIDTH],
   input  logic [LW-1:0]    alReadLreg       [WALK_WIDTH],
   input  logic [PW-1:0]    alReadNewPreg    [WALK_WIDTH],
   input  logic [PW-1:0]    alReadPrevPreg   [WALK_WIDTH],
   output logic             rmtWriteEn       [WALK_WIDTH],
   output logic [LW-1:0]    rmtWriteLreg     [WALK_WIDTH],
   output logic [PW-1:0]    rmtWritePreg     [WALK_WIDTH],
   output logic             freeListPushEn   [WALK_WIDTH],
   output logic [PW-1:0]    freeListPushPreg [WALK_WIDTH],
   output logic             busy,
   output logic             done,
   output logic             protocolError
);

   // remaining needs one extra bit so a count equal to AL_ENTRY_NUM-1 plus
   // the post-decrement underflow stay unambiguous
   localparam int unsigned RW = AL_IW + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WALK = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [AL_IW-1:0] cur_q, cur_d;
   logic [RW-1:0]    remaining_q, remaining_d;
   logic             protocol_error_q, protocol_error_d;

   logic             last_cycle;
   logic             lane_wr [WALK_WIDTH];

   assign busy          = (state_q == ST_WALK);
   assign last_cycle    = (remaining_q <= RW'(WALK_WIDTH));
   assign done          = busy && last_cycle;
   assign protocolError = protocol_error_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_IDLE;
         cur_q            <= '0;
         remaining_q      <= '0;
         protocol_error_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         cur_q            <= cur_d;
         remaining_q      <= remaining_d;
         protocol_error_q <= protocol_error_d;
      end
   end

   // Next-state: latch the range on start, then step WALK_WIDTH per cycle
   always_comb begin
      state_d          = state_q;
      cur_d            = cur_q;
      remaining_d      = remaining_q;
      protocol_error_d = protocol_error_q;
      case (state_q)
         ST_IDLE: begin
            if (toRecoveryPhase) begin
               cur_d       = flushRangeTailPtr - AL_IW'(1);
               remaining_d = {1'b0, AL_IW'(flushRangeTailPtr - flushRangeHeadPtr)};
               state_d     = ST_WALK;
            end
         end
         ST_WALK: begin
            cur_d       = cur_q - AL_IW'(WALK_WIDTH);
            remaining_d = remaining_q - RW'(WALK_WIDTH);
            if (last_cycle) begin
               state_d = ST_IDLE;
            end
            // a restart during the walk is ignored but remembered
            if (toRecoveryPhase) begin
               protocol_error_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Lane addressing and per-lane "valid and writes a destination"
   always_comb begin
      for (int unsigned i = 0; i < WALK_WIDTH; i++) begin
         alReadPtr[i] = cur_q - AL_IW'(i);
         lane_wr[i]   = busy && (RW'(i) < remaining_q) && alReadWriteReg[i];
      end
   end

   // Restore/return ports; an older lane with the same lreg suppresses the
   // younger lane's RMT write so the oldest prevPreg survives
   always_comb begin
      for (int unsigned i = 0; i < WALK_WIDTH; i++) begin
         rmtWriteEn[i]       = 1'b0;
         rmtWriteLreg[i]     = '0;
         rmtWritePreg[i]     = '0;
         freeListPushEn[i]   = 1'b0;
         freeListPushPreg[i] = '0;
         if (lane_wr[i]) begin
            freeListPushEn[i]   = 1'b1;
            freeListPushPreg[i] = alReadNewPreg[i];
            rmtWriteEn[i]       = 1'b1;
            rmtWriteLreg[i]     = alReadLreg[i];
            rmtWritePreg[i]     = alReadPrevPreg[i];
            for (int unsigned k = i + 1; k < WALK_WIDTH; k++) begin
               if (lane_wr[k] && (alReadLreg[k] == alReadLreg[i])) begin
                  rmtWriteEn[i]   = 1'b0;
                  rmtWriteLreg[i] = '0;
                  rmtWritePreg[i] = '0;
               end
            end
         end
      end
   end

endmodule
